// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_pkg
//  Description : funct3 encodings, responder states and lane helpers shared
//                by the data-memory responder and its storage array.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] ctrl,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (ctrl)
            F3_B, F3_BU: be = 4'b0001 << offset;
            F3_H, F3_HU: be = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-align the addressed byte/half, then extend according to funct3.
    function automatic logic [31:0] load_extract(input logic [2:0]  ctrl,
                                                 input logic [1:0]  offset,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {offset, 3'b000};
        case (ctrl)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            F3_W:    res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port DEPTH_WORDS x 32 byte-enabled synchronous RAM
//                with a registered read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    // One byte-wide bank per lane keeps each lane's write independent.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[g]) begin
                        r_mem[idx] <= wdata[8*g +: 8];
                    end
                end else begin
                    r_rd <= r_mem[idx];
                end
            end
        end

        assign rdata[8*g +: 8] = r_rd;
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Far-side MEM-stage responder: byte/half/word loads and stores
//                with configurable wait states and alignment checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_i,
    input  logic [SIZE-1:0] addr_i,
    input  logic [SIZE-1:0] wdata_i,
    input  logic [2:0]      ctrl_i,
    input  logic            rw_i,
    output logic [SIZE-1:0] rdata_o,
    output logic            ready_o,
    output logic            err_o
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

    resp_state_t       r_state;
    resp_state_t       w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic              w_to_resp;

    logic [IDX_W+1:0]  r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_ctrl;
    logic              r_rw;
    logic              r_err;

    logic [IDX_W+1:0]  w_src_addr;
    logic [31:0]       w_src_wdata;
    logic [2:0]        w_src_ctrl;
    logic              w_src_rw;
    logic              w_err;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [3:0]        w_mem_be;
    logic [31:0]       w_mem_wdata;
    logic [31:0]       w_mem_rdata;

    // Upper address bits alias onto the array.
    logic              w_unused_addr;
    assign w_unused_addr = ^addr_i[SIZE-1:IDX_W+2];

    // With zero wait states the array is accessed on the accepting edge, so
    // the live request fields are used before they have been latched.
    assign w_src_addr  = (r_state == IDLE) ? addr_i[IDX_W+1:0] : r_addr;
    assign w_src_wdata = (r_state == IDLE) ? wdata_i[31:0]     : r_wdata;
    assign w_src_ctrl  = (r_state == IDLE) ? ctrl_i            : r_ctrl;
    assign w_src_rw    = (r_state == IDLE) ? rw_i              : r_rw;

    always_comb begin
        w_err = 1'b0;
        case (w_src_ctrl)
            F3_B, F3_BU: w_err = 1'b0;
            F3_H, F3_HU: w_err = w_src_addr[0];
            F3_W:        w_err = |w_src_addr[1:0];
            default:     w_err = 1'b1;
        endcase
        if (w_src_rw && w_src_ctrl[2]) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_to_resp    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_next_cnt = c_WAIT;
                    if (c_WAIT == 4'd0) begin
                        w_next_state = RESP;
                        w_to_resp    = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = RESP;
                    w_next_cnt   = 4'd0;
                    w_to_resp    = 1'b1;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_ctrl  <= F3_B;
            r_rw    <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE && req_i) begin
            r_addr  <= addr_i[IDX_W+1:0];
            r_wdata <= wdata_i[31:0];
            r_ctrl  <= ctrl_i;
            r_rw    <= rw_i;
            r_err   <= w_err;
        end
    end

    // A reset on the edge entering RESP must suppress the commit.
    assign w_mem_en    = w_to_resp && !reset;
    assign w_mem_we    = w_src_rw && !w_err;
    assign w_mem_be    = byte_enable(w_src_ctrl, w_src_addr[1:0]);
    assign w_mem_wdata = w_src_wdata << {w_src_addr[1:0], 3'b000};

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .be    (w_mem_be),
        .idx   (w_src_addr[IDX_W+1:2]),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    assign ready_o = (r_state == RESP);
    assign err_o   = ready_o && r_err;
    assign rdata_o = (ready_o && !r_rw && !r_err)
                   ? load_extract(r_ctrl, r_addr[1:0], w_mem_rdata)
                   : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Bench for data_mem_responder with one- and zero-wait-state
//                instances checked against a byte-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int NB    = DEPTH * 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][2:0]  ctrl;
    logic [1:0]       rw;
    logic [1:0][31:0] rdata;
    logic [1:0]       ready;
    logic [1:0]       err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit started = 1'b0;

    int          wait_cyc [2] = '{1, 0};
    logic        pend     [2] = '{1'b0, 1'b0};
    int          exp_cyc  [2];
    logic [31:0] exp_rd   [2];
    logic        exp_err  [2];
    logic [7:0]  mdl      [2][NB];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.SIZE(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_w1 (
        .clk(clk), .reset(reset), .req_i(req[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .ctrl_i(ctrl[0]), .rw_i(rw[0]), .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0])
    );

    data_mem_responder #(.SIZE(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_i(req[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .ctrl_i(ctrl[1]), .rw_i(rw[1]), .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Access semantics from the rules: size from funct3, natural alignment,
    // byte-addressed memory modulo the array size, extension by arithmetic.
    function automatic void model_access(input int d, input logic w, input logic [2:0] c,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic e, output logic [31:0] rd);
        int n;
        int base;
        longint v;
        n = (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
        e = (c[1:0] == 2'd3) || (c == 3'b110) || (c == 3'b111) || (w && c[2]) || ((a % n) != 0);
        rd = 32'h0;
        if (e) return;
        base = int'(a % NB);
        if (w) begin
            for (int i = 0; i < n; i++) mdl[d][base + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(mdl[d][base + i]) << (8 * i));
            if (!c[2] && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
            rd = v[31:0];
        end
    endfunction

    // Returns what the DUT presented while ready_o was high, and the number
    // of edges between the accepting edge and the edge that raised ready_o.
    task automatic access(input int d, input logic w, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic got_err, output int lat);
        int k;
        logic e;
        logic [31:0] r;
        bit seen;
        @(negedge clk);
        req[d] = 1'b1; rw[d] = w; ctrl[d] = c; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        k = cyc;
        model_access(d, w, c, a, wd, e, r);
        exp_err[d] = e; exp_rd[d] = r; exp_cyc[d] = k + wait_cyc[d]; pend[d] = 1'b1;
        seen = 1'b0; got_rd = 32'h0; got_err = 1'b0; lat = -1;
        for (int t = 0; t < 40; t++) begin
            if (ready[d]) begin
                seen = 1'b1; got_rd = rdata[d]; got_err = err[d]; lat = cyc - k;
                break;
            end
            @(negedge clk);
        end
        req[d] = 1'b0;
        if (!seen) begin
            checks++; fails++;
            $display("FAIL timeout dut%0d ready_o never rose got=0 want=1", d);
        end
    endtask

    always begin : p_compare
        logic exp_r;
        @(negedge clk);
        #1;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                exp_r = pend[d] && (cyc == exp_cyc[d]);
                chk($sformatf("ready_o dut%0d cyc%0d", d, cyc), {31'h0, ready[d]}, {31'h0, exp_r});
                if (exp_r) begin
                    chk($sformatf("rdata_o dut%0d", d), rdata[d], exp_rd[d]);
                    chk($sformatf("err_o dut%0d", d), {31'h0, err[d]}, {31'h0, exp_err[d]});
                end
                if (pend[d] && cyc >= exp_cyc[d]) pend[d] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          l;
        reset = 1'b1; req = '0; addr = '0; wdata = '0; ctrl = '0; rw = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset ready_o dut%0d", d), {31'h0, ready[d]}, 32'h0);
            chk($sformatf("reset err_o dut%0d", d), {31'h0, err[d]}, 32'h0);
            chk($sformatf("reset rdata_o dut%0d", d), rdata[d], 32'h0);
        end
        reset = 1'b0;
        started = 1'b1;

        // One wait state: ready_o rises on the second edge after the request
        // is first seen, i.e. one edge after the accepting edge.
        access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, l);
        chk("sw latency edges", l, 32'd1);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        chk("lw 0x10", r, 32'hDEADBEEF);
        chk("lw 0x10 err", {31'h0, e}, 32'h0);

        access(0, 1'b1, 3'b000, 32'h13, 32'h123456A5, r, e, l);
        access(0, 1'b0, 3'b000, 32'h13, 32'h0, r, e, l);
        chk("lb 0x13", r, 32'hFFFFFFA5);
        access(0, 1'b0, 3'b100, 32'h13, 32'h0, r, e, l);
        chk("lbu 0x13", r, 32'h000000A5);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        chk("lw after sb", r, 32'hA5ADBEEF);

        access(0, 1'b1, 3'b001, 32'h12, 32'h77778001, r, e, l);
        access(0, 1'b0, 3'b001, 32'h12, 32'h0, r, e, l);
        chk("lh 0x12", r, 32'hFFFF8001);
        access(0, 1'b0, 3'b101, 32'h12, 32'h0, r, e, l);
        chk("lhu 0x12", r, 32'h00008001);

        access(0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, r, e, l);
        chk("sh misaligned err", {31'h0, e}, 32'h1);
        access(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, r, e, l);
        chk("store bu err", {31'h0, e}, 32'h1);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        chk("lw unchanged after errs", r, 32'h8001BEEF);
        access(0, 1'b0, 3'b010, 32'h02, 32'h0, r, e, l);
        chk("lw 0x02 err", {31'h0, e}, 32'h1);
        chk("lw 0x02 rdata", r, 32'h0);
        access(0, 1'b0, 3'b011, 32'h10, 32'h0, r, e, l);
        chk("ctrl 011 err", {31'h0, e}, 32'h1);

        access(0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h0BADF00D, r, e, l);
        access(0, 1'b0, 3'b010, NB - 4, 32'h0, r, e, l);
        chk("lw top alias", r, 32'h0BADF00D);

        // Reset while the store sits in its wait state: nothing commits and
        // no ready pulse appears (the compare process expects ready_o low).
        access(0, 1'b1, 3'b010, 32'h20, 32'h11223344, r, e, l);
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b1; ctrl[0] = 3'b010; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        access(0, 1'b0, 3'b010, 32'h20, 32'h0, r, e, l);
        chk("lw after aborted sw", r, 32'h11223344);

        // Zero wait states with address wrap.
        access(1, 1'b1, 3'b010, NB + 32'h10, 32'hCAFEF00D, r, e, l);
        chk("w0 sw latency edges", l, 32'd0);
        access(1, 1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        chk("w0 lw wrap", r, 32'hCAFEF00D);
        access(1, 1'b0, 3'b000, 32'h11, 32'h0, r, e, l);
        chk("w0 lb 0x11", r, 32'hFFFFFFF0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
